seq_alu: RTL

Parametrised, registered, multi-cycle successor to the combinational ALU. Single-cycle ops (add/sub/logic/shifts) coexist with iterative multiply (unsigned/signed) and unsigned divide/remainder. Operand and result transfers use valid/ready handshakes with a registered flag set. Sits between operand-fetch and writeback in the datapath.

---
 rtl/seq_alu_if.sv | 41 ++++
 rtl/seq_alu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Operand/result bus for seq_alu.
//
// Handshake rules, both channels:
//   - A transfer happens on a rising clk edge where valid && ready are both high.
//   - The producer must keep its payload stable while valid is high and ready is low.
//   - The producer may not withdraw valid before the transfer completes.
//   - in_ready is high only while the ALU is idle.
//   - out_valid stays high, with the result held, until out_ready is seen.
interface seq_alu_if #(
  parameter int N = 8
);
  // Operand channel (producer -> ALU)
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;

  // Result channel (ALU -> consumer)
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         cout;
  logic         overflow;
  logic         sign;
  logic         zero;
  logic         divz;

  // Operand fetch / writeback side
  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, out, cout, overflow, sign, zero, divz
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, out, cout, overflow, sign, zero, divz
  );
endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU.
// Single-cycle ops are evaluated in one EXEC cycle. MUL/SMUL/UDIV/UREM run
// N shift-add or restoring-divide steps in ITER. They then pass through EXEC,
// where the final result and flags are formed from the partials.
// EXEC loads the result registers and the FSM moves to DONE.
// out_valid rises one cycle after entering DONE.
// Latency from accept is therefore 2 cycles for single-cycle ops.
// It is N+2 cycles for iterative ops.
module seq_alu #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LSL  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_ASR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_SMUL = 4'd9;
  localparam logic [3:0] OP_UDIV = 4'd10;
  localparam logic [3:0] OP_UREM = 4'd11;

  localparam logic [N-1:0]  N_LIT     = N'(N);
  localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

  state_t state_q, state_d;

  // Operands latched at accept
  logic [3:0]   opc_q;
  logic [N-1:0] opa_q;
  logic [N-1:0] opb_q;
  logic         cin_q;
  logic         neg_q;

  // Iteration partials.
  // Multiply: hi = running upper half, lo = multiplier shifting out / product low half.
  // Divide:   hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;
  logic [SW-1:0] cnt_q;

  // Registered result
  logic         out_valid_q;
  logic [N-1:0] out_q;
  logic         cout_q;
  logic         ovf_q;
  logic         sign_q;
  logic         zero_q;
  logic         divz_q;

  logic         accept;
  logic         in_is_iter;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  // A divide by zero takes the EXEC path and never enters ITER.
  assign in_is_iter = (bus.op == OP_MUL) || (bus.op == OP_SMUL) ||
                      (((bus.op == OP_UDIV) || (bus.op == OP_UREM)) && (bus.b != '0));
  // Magnitudes for signed multiply.
  // The most negative value maps to 2^(N-1), which still fits unsigned in N bits.
  assign a_mag = bus.a[N-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[N-1] ? -bus.b : bus.b;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.sign      = sign_q;
  assign bus.zero      = zero_q;
  assign bus.divz      = divz_q;
  assign fsm_state     = state_q;

  // ---------------------------------------------------------------
  // One iteration step for the multi-cycle ops
  // ---------------------------------------------------------------
  logic [N:0]   mul_sum;
  logic [N:0]   div_sh;
  logic [N:0]   div_diff;
  logic         div_fits;
  logic [N-1:0] step_hi;
  logic [N-1:0] step_lo;

  // Shift-add multiply step or restoring divide step, selected by the latched op.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_sh   = {hi_q, lo_q[N-1]};
    div_diff = div_sh - {1'b0, opb_q};
    // Partial remainder stays below the divisor, so the difference fits in N+1 signed bits.
    div_fits = ~div_diff[N];
    step_hi  = hi_q;
    step_lo  = lo_q;
    if ((opc_q == OP_MUL) || (opc_q == OP_SMUL)) begin
      step_hi = mul_sum[N:1];
      step_lo = {mul_sum[0], lo_q[N-1:1]};
    end else begin
      step_hi = div_fits ? div_diff[N-1:0] : div_sh[N-1:0];
      step_lo = {lo_q[N-2:0], div_fits};
    end
  end

  // ---------------------------------------------------------------
  // Result formation in EXEC
  // ---------------------------------------------------------------
  logic [N:0]          sum_w;
  logic [N:0]          diff_w;
  logic [N:0]          lsl_w;
  logic [N:0]          lsr_w;
  logic signed [N:0]   asr_w;
  logic                shift_zero;
  logic                shift_big;
  logic [2*N-1:0]      prod;
  logic [2*N-1:0]      sprod;
  logic [N-1:0]        res_out;
  logic                res_cout;
  logic                res_ovf;
  logic                res_divz;

  // Evaluate the latched op (or finalise the iterative partials) into result and flags.
  always_comb begin
    sum_w  = {1'b0, opa_q} + {1'b0, opb_q} + {{N{1'b0}}, cin_q};
    diff_w = {1'b0, opa_q} - {1'b0, opb_q} - {{N{1'b0}}, cin_q};
    // One extra bit on the side the data leaves from catches the last bit shifted out.
    lsl_w  = {1'b0, opa_q} << opb_q;
    lsr_w  = {opa_q, 1'b0} >> opb_q;
    asr_w  = $signed({opa_q, 1'b0}) >>> opb_q;
    shift_zero = (opb_q == '0);
    shift_big  = (opb_q > N_LIT);
    prod   = {hi_q, lo_q};
    sprod  = neg_q ? -prod : prod;

    res_out  = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    res_divz = 1'b0;

    case (opc_q)
      OP_ADD: begin
        res_out  = sum_w[N-1:0];
        res_cout = sum_w[N];
        res_ovf  = (opa_q[N-1] == opb_q[N-1]) && (sum_w[N-1] != opa_q[N-1]);
      end
      OP_SUB: begin
        res_out  = diff_w[N-1:0];
        res_cout = diff_w[N];
        res_ovf  = (opa_q[N-1] != opb_q[N-1]) && (diff_w[N-1] != opa_q[N-1]);
      end
      OP_AND: res_out = opa_q & opb_q;
      OP_OR:  res_out = opa_q | opb_q;
      OP_XOR: res_out = opa_q ^ opb_q;
      OP_LSL: begin
        if (shift_zero) begin
          res_out = opa_q;
        end else if (!shift_big) begin
          res_out  = lsl_w[N-1:0];
          res_cout = lsl_w[N];
        end
      end
      OP_LSR: begin
        if (shift_zero) begin
          res_out = opa_q;
        end else if (!shift_big) begin
          res_out  = lsr_w[N:1];
          res_cout = lsr_w[0];
        end
      end
      OP_ASR: begin
        if (shift_zero) begin
          res_out = opa_q;
        end else if (shift_big) begin
          res_out  = {N{opa_q[N-1]}};
          res_cout = opa_q[N-1];
        end else begin
          res_out  = asr_w[N:1];
          res_cout = asr_w[0];
        end
      end
      OP_MUL: begin
        res_out = prod[N-1:0];
        res_ovf = |prod[2*N-1:N];
      end
      OP_SMUL: begin
        res_out = sprod[N-1:0];
        res_ovf = !((&sprod[2*N-1:N-1]) || (~|sprod[2*N-1:N-1]));
      end
      OP_UDIV: begin
        if (opb_q == '0) begin
          res_out  = '1;
          res_divz = 1'b1;
        end else begin
          res_out = lo_q;
        end
      end
      OP_UREM: begin
        if (opb_q == '0) begin
          res_out  = opa_q;
          res_divz = 1'b1;
        end else begin
          res_out = hi_q;
        end
      end
      default: res_out = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. DONE never accepts directly, so results do not overlap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = in_is_iter ? ITER : EXEC;
      ITER: if (cnt_q == LAST_STEP) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------

  // Latch operands on accept and advance the partials each ITER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cin_q <= 1'b0;
      neg_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      opc_q <= bus.op;
      opa_q <= bus.a;
      opb_q <= bus.b;
      cin_q <= bus.cin;
      neg_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= bus.a;
      cnt_q <= '0;
      if (bus.op == OP_MUL) begin
        lo_q <= bus.b;
      end else if (bus.op == OP_SMUL) begin
        opa_q <= a_mag;
        lo_q  <= b_mag;
        neg_q <= bus.a[N-1] ^ bus.b[N-1];
      end
    end else if (state_q == ITER) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture the result in EXEC.
  // Raise out_valid a cycle later and drop it on the consumer handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      divz_q      <= 1'b0;
    end else begin
      if (state_q == EXEC) begin
        out_q  <= res_out;
        cout_q <= res_cout;
        ovf_q  <= res_ovf;
        sign_q <= res_out[N-1];
        zero_q <= (res_out == '0);
        divz_q <= res_divz;
      end
      if ((state_q == DONE) && !out_valid_q) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
